// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Fetch/decode control FSM sitting between the byte-wide program memory, the
// program counter and the datapath. It reads opcodes and operand bytes at the
// address the PC presents, executes control flow (JMP, JMPC, CALL, RET, HALT)
// itself by pulsing the PC command inputs, and offers every other opcode to
// the datapath over a valid/ready handshake.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-high reset (also resets the PC to 0)
//   mem_data_i     program memory read data, 1-cycle latency from PC address
//   cond_flag_i    datapath condition flag, looked at only for JMPC
//   exec_ready_i   datapath accepts the offered instruction
//   inc_o          PC increment pulse
//   jmp_o          PC jump pulse (target on addr_in_o)
//   call_o         PC call pulse (target on addr_in_o)
//   ret_o          PC return pulse
//   addr_in_o      jump/call target, 0 whenever jmp_o and call_o are low
//   exec_valid_o   datapath instruction offered
//   exec_opcode_o  instruction register contents
//   halted_o       sequencer stopped at HALT
//
// Timing per instruction: NOP/RET 2 cycles, JMP/JMPC/CALL 4 cycles,
// datapath op 3 cycles plus any cycles exec_ready_i is held low.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [7:0] OP_NOP  = 8'h00,
    parameter logic [7:0] OP_JMP  = 8'h10,
    parameter logic [7:0] OP_JMPC = 8'h11,
    parameter logic [7:0] OP_CALL = 8'h12,
    parameter logic [7:0] OP_RET  = 8'h13,
    parameter logic [7:0] OP_HALT = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_data_i,
    input  logic       cond_flag_i,
    input  logic       exec_ready_i,
    output logic       inc_o,
    output logic       jmp_o,
    output logic       call_o,
    output logic       ret_o,
    output logic [7:0] addr_in_o,
    output logic       exec_valid_o,
    output logic [7:0] exec_opcode_o,
    output logic       halted_o
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_OPWAIT  = 3'd3,
        ST_OPERAND = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic [7:0] ir_q;
    logic [7:0] ir_d;

    // State and instruction register, asynchronously cleared by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and instruction-register update logic.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                // Memory read of the opcode byte is in flight.
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d = mem_data_i;
                case (mem_data_i)
                    OP_NOP, OP_RET:           state_d = ST_FETCH;
                    OP_HALT:                  state_d = ST_HALT;
                    OP_JMP, OP_JMPC, OP_CALL: state_d = ST_OPWAIT;
                    // Unlisted opcodes are datapath ops; there is no trap.
                    default:                  state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (exec_ready_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_OPWAIT: begin
                // Memory read of the operand byte is in flight.
                state_d = ST_OPERAND;
            end
            ST_OPERAND: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                // Only rst leaves HALT.
                state_d = ST_HALT;
            end
            default: begin
                // Unused encodings recover to a clean fetch.
                state_d = ST_FETCH;
            end
        endcase
    end

    // PC command pulses and datapath/status outputs from registered state.
    always_comb begin
        inc_o         = 1'b0;
        jmp_o         = 1'b0;
        call_o        = 1'b0;
        ret_o         = 1'b0;
        addr_in_o     = 8'h00;
        exec_valid_o  = 1'b0;
        halted_o      = 1'b0;
        exec_opcode_o = ir_q;
        case (state_q)
            ST_FETCH: begin
                inc_o = 1'b0;
            end
            ST_DECODE: begin
                case (mem_data_i)
                    OP_NOP:                   inc_o = 1'b1;
                    OP_RET:                   ret_o = 1'b1;
                    // Step the PC onto the operand byte.
                    OP_JMP, OP_JMPC, OP_CALL: inc_o = 1'b1;
                    default:                  inc_o = 1'b0;
                endcase
            end
            ST_EXEC: begin
                exec_valid_o = 1'b1;
                // Handshake cycle: move past the accepted opcode.
                if (exec_ready_i) begin
                    inc_o = 1'b1;
                end else begin
                    inc_o = 1'b0;
                end
            end
            ST_OPWAIT: begin
                inc_o = 1'b0;
            end
            ST_OPERAND: begin
                case (ir_q)
                    OP_JMP: begin
                        jmp_o     = 1'b1;
                        addr_in_o = mem_data_i;
                    end
                    OP_JMPC: begin
                        if (cond_flag_i) begin
                            jmp_o     = 1'b1;
                            addr_in_o = mem_data_i;
                        end else begin
                            // Not taken: skip over the operand byte.
                            inc_o = 1'b1;
                        end
                    end
                    OP_CALL: begin
                        // The PC saves the operand address itself; RET
                        // resumes two bytes later, past the unfetched pad.
                        call_o    = 1'b1;
                        addr_in_o = mem_data_i;
                    end
                    default: begin
                        inc_o = 1'b0;
                    end
                endcase
            end
            ST_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                halted_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a PC + synchronous memory model closes the
// loop; stimulus pushes hand-computed expected events, a monitor pops them
// whenever the DUT shows a pulse, a rising exec_valid or a rising halted.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_data = 8'h00;
    logic       cond_flag = 1'b0;
    logic       exec_ready = 1'b0;
    logic       inc, jmp, call, ret, exec_valid, halted;
    logic [7:0] addr_in, exec_opcode;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .mem_data_i    (mem_data),
        .cond_flag_i   (cond_flag),
        .exec_ready_i  (exec_ready),
        .inc_o         (inc),
        .jmp_o         (jmp),
        .call_o        (call),
        .ret_o         (ret),
        .addr_in_o     (addr_in),
        .exec_valid_o  (exec_valid),
        .exec_opcode_o (exec_opcode),
        .halted_o      (halted)
    );

    always #5 clk = ~clk;

    // Program memory and PC model
    logic [7:0] mem [0:255];
    logic [7:0] pc_m;
    logic [7:0] save_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_m     <= 8'h00;
            save_m   <= 8'h00;
            mem_data <= 8'h00;
        end else begin
            mem_data <= mem[pc_m];
            if (inc) begin
                pc_m <= pc_m + 8'd1;
            end else if (jmp) begin
                pc_m <= addr_in;
            end else if (call) begin
                save_m <= pc_m;
                pc_m   <= addr_in;
            end else if (ret) begin
                pc_m <= save_m + 8'd2;
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic [3:0] p;     // {inc, jmp, call, ret}
        logic [7:0] addr;
        logic       ev;
        logic [7:0] eop;
        logic       hl;
        logic [7:0] pc;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic       prev_ev = 1'b0;
    logic       prev_hl = 1'b0;
    logic [7:0] exp_eop = 8'h00;
    string      scen = "init";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%0h, required 0x%0h (cycle %0d)", scen, name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [3:0] p, input logic [7:0] addr, input logic ev,
                        input logic hl, input logic [7:0] pc, input int c);
        exp_t e;
        e.p = p; e.addr = addr; e.ev = ev; e.eop = exp_eop; e.hl = hl; e.pc = pc; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc     = 0;
                prev_ev = 1'b0;
                prev_hl = 1'b0;
            end else begin
                cyc++;
                if (!jmp && !call) chk("addr_idle", {24'd0, addr_in}, 32'd0);
                if (exec_valid) chk("opcode_hold", {24'd0, exec_opcode}, {24'd0, exp_eop});
                if (inc || jmp || call || ret || (exec_valid && !prev_ev) || (halted && !prev_hl)) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL %s/unexpected: got pulses %b addr 0x%0h ev %b halted %b, required no event (cycle %0d)",
                                 scen, {inc, jmp, call, ret}, addr_in, exec_valid, halted, cyc);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("cycle", cyc, e.cyc);
                        chk("pulses", {28'd0, inc, jmp, call, ret}, {28'd0, e.p});
                        chk("addr_in", {24'd0, addr_in}, {24'd0, e.addr});
                        chk("exec_valid", {31'd0, exec_valid}, {31'd0, e.ev});
                        if (e.ev) chk("exec_opcode", {24'd0, exec_opcode}, {24'd0, e.eop});
                        chk("halted", {31'd0, halted}, {31'd0, e.hl});
                        chk("pc", {24'd0, pc_m}, {24'd0, e.pc});
                    end
                end
                prev_ev = exec_valid;
                prev_hl = halted;
            end
        end
    end

    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_INC  = 4'b1000;
    localparam logic [3:0] P_JMP  = 4'b0100;
    localparam logic [3:0] P_CALL = 4'b0010;
    localparam logic [3:0] P_RET  = 4'b0001;

    task automatic begin_scen(input string name);
        rst        = 1'b1;
        scen       = name;
        cond_flag  = 1'b0;
        exec_ready = 1'b0;
        exp_eop    = 8'h00;
        exp_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic all_zero(input string name);
        chk(name, {16'd0, inc, jmp, call, ret, exec_valid, halted, 2'b00, addr_in}, 32'd0);
        chk({name, "_op"}, {24'd0, exec_opcode}, 32'd0);
    endtask

    // Holds rst, checks outputs are quiet, then releases just after a rising
    // edge so that the following cycle is cycle 1 (FETCH).
    task automatic release_rst();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        all_zero("reset_outs");
        rst = 1'b0;
    endtask

    task automatic run_end(input int n);
        repeat (n) @(posedge clk);
        #1;
        chk("pending", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        // NOP stream then HALT at 4
        begin_scen("nop");
        mem[4] = 8'hFF;
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h00, 2);
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h01, 4);
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h02, 6);
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h03, 8);
        push(P_NONE, 8'h00, 1'b0, 1'b1, 8'h04, 11);
        release_rst();
        run_end(20);

        // JMP to 0x40
        begin_scen("jmp");
        mem[0] = 8'h10; mem[1] = 8'h40; mem[8'h40] = 8'hFF;
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h00, 2);
        push(P_JMP, 8'h40, 1'b0, 1'b0, 8'h01, 4);
        push(P_NONE, 8'h00, 1'b0, 1'b1, 8'h40, 7);
        release_rst();
        run_end(15);

        // JMPC not taken
        begin_scen("jmpc0");
        mem[0] = 8'h11; mem[1] = 8'h20; mem[2] = 8'hFF; mem[8'h20] = 8'hFF;
        cond_flag = 1'b0;
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h00, 2);
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h01, 4);
        push(P_NONE, 8'h00, 1'b0, 1'b1, 8'h02, 7);
        release_rst();
        run_end(15);

        // JMPC taken
        begin_scen("jmpc1");
        mem[0] = 8'h11; mem[1] = 8'h20; mem[2] = 8'hFF; mem[8'h20] = 8'hFF;
        cond_flag = 1'b1;
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h00, 2);
        push(P_JMP, 8'h20, 1'b0, 1'b0, 8'h01, 4);
        push(P_NONE, 8'h00, 1'b0, 1'b1, 8'h20, 7);
        release_rst();
        run_end(15);

        // CALL at 5, RET at 0x30, resume at 8
        begin_scen("call_ret");
        mem[5] = 8'h12; mem[6] = 8'h30; mem[7] = 8'hFF; mem[8'h30] = 8'h13; mem[8] = 8'hFF;
        for (int i = 0; i < 5; i++) push(P_INC, 8'h00, 1'b0, 1'b0, i[7:0], 2 + 2 * i);
        push(P_INC,  8'h00, 1'b0, 1'b0, 8'h05, 12);
        push(P_CALL, 8'h30, 1'b0, 1'b0, 8'h06, 14);
        push(P_RET,  8'h00, 1'b0, 1'b0, 8'h30, 16);
        push(P_NONE, 8'h00, 1'b0, 1'b1, 8'h08, 19);
        release_rst();
        run_end(25);

        // Datapath op with exec_ready low for 3 cycles
        begin_scen("exec_wait");
        mem[0] = 8'h42; mem[1] = 8'hFF;
        exp_eop = 8'h42;
        push(P_NONE, 8'h00, 1'b1, 1'b0, 8'h00, 3);
        push(P_INC,  8'h00, 1'b1, 1'b0, 8'h00, 6);
        push(P_NONE, 8'h00, 1'b0, 1'b1, 8'h01, 9);
        release_rst();
        repeat (5) @(posedge clk);
        #1 exec_ready = 1'b1;
        @(posedge clk);
        #1 exec_ready = 1'b0;
        run_end(10);

        // exec_ready held high outside EXEC has no effect
        begin_scen("exec_ready_hi");
        mem[0] = 8'h00; mem[1] = 8'h55; mem[2] = 8'hFF;
        exec_ready = 1'b1;
        exp_eop = 8'h55;
        push(P_INC,  8'h00, 1'b0, 1'b0, 8'h00, 2);
        push(P_INC,  8'h00, 1'b1, 1'b0, 8'h01, 5);
        push(P_NONE, 8'h00, 1'b0, 1'b1, 8'h02, 8);
        release_rst();
        run_end(15);

        // HALT at 0 stays halted, no pulses
        begin_scen("halt");
        mem[0] = 8'hFF;
        push(P_NONE, 8'h00, 1'b0, 1'b1, 8'h00, 3);
        release_rst();
        run_end(30);
        chk("halt_sticky", {31'd0, halted}, 32'd1);

        // Reset asserted in OPWAIT of a JMP, then clean restart from 0
        begin_scen("mid_rst");
        mem[0] = 8'h10; mem[1] = 8'h40; mem[8'h40] = 8'hFF;
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h00, 2);
        release_rst();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        all_zero("async_rst");
        chk("pc_rst", {24'd0, pc_m}, 32'd0);
        chk("pending", exp_q.size(), 32'd0);
        push(P_INC, 8'h00, 1'b0, 1'b0, 8'h00, 2);
        push(P_JMP, 8'h40, 1'b0, 1'b0, 8'h01, 4);
        push(P_NONE, 8'h00, 1'b0, 1'b1, 8'h40, 7);
        release_rst();
        run_end(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
